// File: rtl/mem_bus_pkg.sv
// Shared bus types for the memory copy subsystem: request struct, mode codes
// and the copier state encoding.
package mem_bus_pkg;

  localparam logic [1:0] MODE_NOP   = 2'b00;
  localparam logic [1:0] MODE_WRITE = 2'b01;
  localparam logic [1:0] MODE_READ  = 2'b10;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  mode;
    logic [31:0] offset;
    logic [31:0] address;
  } mem_in_bus_t;

  typedef enum logic [1:0] {
    CP_IDLE,
    CP_READ,
    CP_WRITE,
    CP_DONE
  } copier_state_t;

endpackage

// File: rtl/mem_bus_if.sv
// Memory request bus: a master issues mem_in_bus_t requests, the memory side consumes them.
interface mem_bus_if;
  import mem_bus_pkg::*;

  mem_in_bus_t req;

  modport master (output req);
  modport slave  (input  req);

endinterface

// File: rtl/mem_copier.sv
// DMA-style copier: alternates READ of src+index and WRITE of the read data to dest+index.
module mem_copier
  import mem_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] copy_src,
  input  logic [31:0] copy_len,
  input  logic [31:0] copy_dest,
  input  logic [31:0] rd_data,
  output mem_in_bus_t req,
  output logic        finished
);

  copier_state_t state, state_nxt;
  logic [31:0]   index, src_q, len_q, dest_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= CP_IDLE;
      index  <= '0;
      src_q  <= '0;
      len_q  <= '0;
      dest_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == CP_IDLE && enable) begin
        src_q  <= copy_src;
        len_q  <= copy_len;
        dest_q <= copy_dest;
        index  <= '0;
      end else if (state == CP_WRITE) begin
        index <= index + 32'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = CP_IDLE;
    end else begin
      case (state)
        CP_IDLE:  state_nxt = (copy_len == '0) ? CP_DONE : CP_READ;
        CP_READ:  state_nxt = CP_WRITE;
        CP_WRITE: state_nxt = (index + 32'd1 == len_q) ? CP_DONE : CP_READ;
        CP_DONE:  state_nxt = CP_DONE;
        default:  state_nxt = CP_IDLE;
      endcase
    end
  end

  // The read data register feeds straight back as write data on the following cycle.
  always_comb begin
    req      = '0;
    finished = (state == CP_DONE);
    case (state)
      CP_READ: begin
        req.mode    = MODE_READ;
        req.address = src_q;
        req.offset  = index;
      end
      CP_WRITE: begin
        req.mode    = MODE_WRITE;
        req.address = dest_q;
        req.offset  = index;
        req.data    = rd_data;
      end
      default: req = '0;
    endcase
  end

endmodule

// File: rtl/mem_in_bus_buf.sv
// Per-master enable gate: passes the request when enabled, otherwise presents an all-zero NOP.
module mem_in_bus_buf
  import mem_bus_pkg::*;
(
  input  logic        enable,
  input  mem_in_bus_t bus_in,
  output mem_in_bus_t bus_out
);

  always_comb begin
    bus_out = '0;
    if (enable) bus_out = bus_in;
  end

endmodule

// File: rtl/mem_sys.sv
// Word-addressed synchronous memory with a registered read port.
module mem_sys
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  mem_in_bus_t       mem_in,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];
  logic [ADDR_W-1:0] ea;

  // Address arithmetic wraps at the implemented depth.
  assign ea = ADDR_W'(mem_in.address + mem_in.offset);

  // Storage is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_in.mode == MODE_WRITE) mem[ea] <= DATA_W'(mem_in.data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (mem_in.mode == MODE_READ) begin
      data_out <= mem[ea];
    end
  end

endmodule

// File: rtl/mem_copy_subsystem.sv
// Memory with a manual master and a block copier; enable_manual selects which one owns the bus.
module mem_copy_subsystem
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_mem_n,
  mem_bus_if.slave          manual_mem_in,
  input  logic              enable_manual,
  input  logic [31:0]       copy_src,
  input  logic [31:0]       copy_len,
  input  logic [31:0]       copy_dest,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              copier_finished
);

  mem_in_bus_t manual_gated, copier_req, copier_gated, mem_in;

  mem_in_bus_buf u_manual_buf (
    .enable  (enable_manual),
    .bus_in  (manual_mem_in.req),
    .bus_out (manual_gated)
  );

  mem_in_bus_buf u_copier_buf (
    .enable  (!enable_manual),
    .bus_in  (copier_req),
    .bus_out (copier_gated)
  );

  // Enables are complementary, so at most one gated bus is non-zero.
  assign mem_in = manual_gated | copier_gated;

  mem_copier u_copier (
    .clk       (clk),
    .rst_n     (reset_mem_n),
    .enable    (!enable_manual),
    .copy_src  (copy_src),
    .copy_len  (copy_len),
    .copy_dest (copy_dest),
    .rd_data   (mem_data_out),
    .req       (copier_req),
    .finished  (copier_finished)
  );

  mem_sys #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .clk      (clk),
    .rst_n    (reset_mem_n),
    .mem_in   (mem_in),
    .data_out (mem_data_out)
  );

endmodule

// File: tb/tb_mem_copy_subsystem.sv
// Scoreboard bench for mem_copy_subsystem: manual reads push expected data, a monitor checks it.
module tb_mem_copy_subsystem;
  import mem_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset_mem_n;
  logic        enable_manual;
  logic [31:0] copy_src, copy_len, copy_dest;
  logic [31:0] mem_data_out;
  logic        copier_finished;

  mem_bus_if manual_if ();

  mem_copy_subsystem #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk             (clk),
    .reset_mem_n     (reset_mem_n),
    .manual_mem_in   (manual_if),
    .enable_manual   (enable_manual),
    .copy_src        (copy_src),
    .copy_len        (copy_len),
    .copy_dest       (copy_dest),
    .mem_data_out    (mem_data_out),
    .copier_finished (copier_finished)
  );

  always #5 clk = ~clk;

  logic [31:0] model_mem [int unsigned];
  logic [31:0] model_dout;
  logic [31:0] exp_q [$];
  int checks   = 0;
  int failures = 0;

  function automatic int unsigned ea(input logic [31:0] a, input logic [31:0] o);
    return (a + o) & 32'h0000_FFFF;
  endfunction

  function automatic logic [31:0] model_rd(input int unsigned addr);
    return model_mem.exists(addr) ? model_mem[addr] : 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One manual bus operation, one cycle long; the model is updated in issue order.
  task automatic op(input logic [1:0] m, input logic [31:0] a, input logic [31:0] o,
                    input logic [31:0] d);
    mem_in_bus_t r;
    @(negedge clk);
    r.data = d; r.mode = m; r.offset = o; r.address = a;
    manual_if.req = r;
    if (m == MODE_WRITE) model_mem[ea(a, o)] = d;
    if (m == MODE_READ) begin
      model_dout = model_rd(ea(a, o));
      exp_q.push_back(model_dout);
    end
    @(posedge clk);
    #1 manual_if.req = '0;
  endtask

  // Forward word-by-word copy of the first n words; overlap propagates by construction.
  task automatic model_copy(input logic [31:0] src, input logic [31:0] dest, input int n);
    for (int i = 0; i < n; i++)
      model_mem[ea(dest, i)] = model_rd(ea(src, i));
  endtask

  task automatic wait_done(input int len, input bit scramble, input string name);
    int seen = 0;
    for (int e = 1; e <= 2 * len + 8 && seen == 0; e++) begin
      @(posedge clk);
      #1;
      if (e == 1 && scramble) begin
        copy_src = $urandom; copy_len = $urandom; copy_dest = $urandom;
      end
      if (copier_finished) seen = e;
    end
    check(name, seen, 2 * len + 1);
    @(posedge clk);
    #1 check({name, "_held"}, copier_finished, 1'b1);
  endtask

  task automatic run_copy(input logic [31:0] src, input logic [31:0] len, input logic [31:0] dest,
                          input bit scramble, input string name);
    @(negedge clk);
    copy_src = src; copy_len = len; copy_dest = dest;
    manual_if.req = '0;
    enable_manual = 1'b0;
    wait_done(int'(len), scramble, name);
  endtask

  task automatic disable_copier(input string name);
    @(negedge clk);
    enable_manual = 1'b1;
    @(posedge clk);
    #1 check(name, copier_finished, 1'b0);
  endtask

  task automatic read_range(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) op(MODE_READ, base, i, 32'h0);
  endtask

  // Scoreboard monitor: any manual READ accepted at an edge must show its data 1 cycle later.
  initial begin
    bit issued;
    logic [31:0] exp;
    forever begin
      @(posedge clk);
      issued = reset_mem_n && enable_manual && (manual_if.req.mode == MODE_READ);
      #1;
      if (issued) begin
        if (exp_q.size() == 0) begin
          check("rd_unexpected", mem_data_out, 32'hxxxx_xxxx);
        end else begin
          exp = exp_q.pop_front();
          check("rd_data", mem_data_out, exp);
        end
      end
    end
  end

  initial begin
    logic [31:0] s, d, l;
    reset_mem_n   = 1'b0;
    enable_manual = 1'b1;
    copy_src = '0; copy_len = '0; copy_dest = '0;
    manual_if.req = '0;
    model_dout = '0;
    #1;
    check("reset_dout", mem_data_out, 32'h0);
    check("reset_finished", copier_finished, 1'b0);
    #20;
    @(negedge clk) reset_mem_n = 1'b1;

    for (int i = 0; i < 4; i++) op(MODE_WRITE, 32'h5555, i, i + 1);
    for (int i = 0; i < 4; i++) op(MODE_WRITE, 32'h5570, i, 32'h0);
    for (int i = 0; i < 4; i++) op(MODE_WRITE, 32'h5580, i, 32'h0);
    op(MODE_READ, 32'h5555, 32'd2, 32'h0);
    op(2'b11, 32'h5555, 32'd0, 32'h0000_DEAD);
    check("mode11_dout_hold", mem_data_out, model_dout);
    op(MODE_WRITE, 32'h5590, 32'd0, 32'h7);
    check("write_dout_hold", mem_data_out, model_dout);
    op(MODE_READ, 32'h5555, 32'd0, 32'h0);

    // Address and offset beyond the implemented width wrap into low memory.
    op(MODE_WRITE, 32'h0001_FFFE, 32'd4, 32'hC0DE_0002);
    op(MODE_READ, 32'h0000_0002, 32'd0, 32'h0);

    run_copy(32'h5555, 32'd3, 32'h5570, 1'b0, "copy3_finish");
    model_copy(32'h5555, 32'h5570, 3);
    disable_copier("copy3_drop");
    read_range(32'h5570, 4);

    run_copy(32'h5555, 32'd0, 32'h5580, 1'b0, "len0_finish");
    disable_copier("len0_drop");
    read_range(32'h5580, 1);

    // Abort after one word has been moved.
    for (int i = 0; i < 4; i++) op(MODE_WRITE, 32'h5570, i, 32'hA0 + i);
    @(negedge clk);
    copy_src = 32'h5555; copy_len = 32'd3; copy_dest = 32'h5570;
    enable_manual = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("abort_not_finished", copier_finished, 1'b0);
    model_copy(32'h5555, 32'h5570, 1);
    disable_copier("abort_drop");
    read_range(32'h5570, 4);
    // A fresh start must take the full IDLE-based latency.
    run_copy(32'h5555, 32'd2, 32'h5572, 1'b0, "restart_finish");
    model_copy(32'h5555, 32'h5572, 2);
    disable_copier("restart_drop");
    read_range(32'h5570, 4);

    // Asynchronous reset in the middle of a copy.
    @(negedge clk);
    copy_src = 32'h5555; copy_len = 32'd3; copy_dest = 32'h5580;
    enable_manual = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset_mem_n = 1'b0;
    #1;
    check("midreset_dout", mem_data_out, 32'h0);
    check("midreset_finished", copier_finished, 1'b0);
    @(negedge clk) reset_mem_n = 1'b1;
    wait_done(3, 1'b0, "after_reset_finish");
    model_copy(32'h5555, 32'h5580, 3);
    disable_copier("after_reset_drop");
    read_range(32'h5580, 4);

    // Randomised copies in a small window, overlap allowed, inputs scrambled mid-copy.
    for (int i = 0; i < 80; i++) op(MODE_WRITE, 32'h1000, i, $urandom);
    for (int t = 0; t < 6; t++) begin
      s = 32'h1000 + $urandom_range(0, 63);
      d = 32'h1000 + $urandom_range(0, 63);
      l = $urandom_range(1, 10);
      run_copy(s, l, d, 1'b1, "rand_finish");
      model_copy(s, d, int'(l));
      disable_copier("rand_drop");
      read_range(d, int'(l) + 1);
      read_range(s, int'(l));
    end

    repeat (3) @(posedge clk);
    #1 check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_copy_subsystem.md
Name: mem_copy_subsystem

Overview:
- Word-addressed memory with two request masters: a manual port (testbench/host) and a DMA-style copier that moves N consecutive words from a source base to a destination base.
- A single enable selects the master: manual when enable_manual=1, copier when enable_manual=0.
- Sits between host control logic and on-chip storage; used for bulk array copies.

Parameters:
- ADDR_W, 16, implemented word-address bits; effective address is truncated to this width (depth 2**ADDR_W words).
- DATA_W, 32, word width; fixed to match the bus struct.

Ports:
- clk  in  1  rising-edge clock.
- reset_mem_n  in  1  asynchronous active-low reset.
- manual_mem_in  in  mem_in_bus_t  manual request: data[31:0], mode[1:0], offset[31:0], address[31:0].
- enable_manual  in  1  1 = manual master drives memory; 0 = copier enabled and drives memory.
- copy_src  in  32  source base word address.
- copy_len  in  32  number of words to copy.
- copy_dest  in  32  destination base word address.
- mem_data_out  out  32  registered read data.
- copier_finished  out  1  copy complete; held until copier is disabled.

Behaviour:
- Mode encoding: 00 NOP, 01 WRITE, 10 READ, 11 reserved (treated as NOP).
- Effective address is (address + offset) mod 2**ADDR_W.
- Memory is synchronous:
  - WRITE stores data at the rising edge.
  - READ loads mem_data_out at the rising edge (1-cycle latency).
  - NOP/WRITE leave mem_data_out unchanged.
- Bus select: mem_in = enable_manual ? manual_mem_in : copier request. The copier request is NOP whenever its state is not READ or WRITE.
- Reset (async, reset_mem_n=0): mem_data_out=0, copier_finished=0, copier state=IDLE, index=0. Array contents are not cleared.
- Copier FSM:
  - IDLE (enable low): outputs NOP. On the first clock with the copier enabled, latch src/len/dest and set index=0. If len==0, go to DONE; otherwise go to READ.
  - READ: issue READ at latched_src+index.
  - WRITE: issue WRITE of mem_data_out to latched_dest+index; index++. If the incremented index==len, go to DONE; else go to READ.
  - DONE: NOP, copier_finished=1.
- Copier timing:
  - 2 cycles per word.
  - copier_finished rises 2*len+1 edges after the enable is sampled.
- Disable (enable_manual=1) in any state returns the copier to IDLE on the next edge. This aborts a copy; copier_finished drops.
- Re-enabling after DONE and a disable re-latches the inputs and starts a new copy.
- Inputs are sampled only at start; changes mid-copy are ignored.
- Overlapping regions: the copy is forward word-by-word. No overlap protection; overlap with dest>src propagates already-copied data (defined, not an error).

Decomposition:
- Package mem_bus_pkg holds:
  - mem_in_bus_t (packed struct: data, mode, offset, address).
  - Mode constants MODE_NOP/WRITE/READ.
  - The copier state enum.
- Sub-modules:
  - mem_sys: storage plus read register.
  - mem_in_bus_buf: per-master enable gate. Drives its bus input when enabled, else NOP; the two outputs are OR-combined, with the enables mutually exclusive by construction.
  - mem_copier: FSM.
- The top level only wires these together.

Test Plan:
- Manual writes 1,2,3,4 at address 0x5555, offsets 0..3. Manual READ at 0x5555+2 -> mem_data_out=3 one cycle later.
- After the writes, copy_src=0x5555, copy_len=3, copy_dest=0x5570, then drop enable_manual:
  - copier_finished=1 after 7 edges.
  - Manual reads of 0x5570..0x5572 return 1,2,3.
  - 0x5573 stays 0 (never written).
- copy_len=0 -> copier_finished=1 on the first enabled edge; no memory writes.
- Raise enable_manual after 3 cycles of a len=3 copy:
  - Only 0x5570 is updated.
  - copier_finished stays 0.
  - The FSM is in IDLE.
- Assert reset_mem_n=0 asynchronously mid-copy -> mem_data_out=0 and copier_finished=0 immediately; the copier restarts from index 0 after release while still enabled.
- Manual mode=11 with data 0xDEAD at 0x5555 -> memory unchanged and mem_data_out unchanged.
